combat_controller: RTL and testbench

COMBAT_CONTROLLER -- requirements
Module: combat_controller

---
 rtl/combat_pkg.sv | 30 +++
 rtl/fighter_fsm.sv | 109 ++++++++++
 rtl/combat_controller.sv | 157 +++++++++++++++
 tb/tb_combat_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combat_pkg.sv
// Shared types, constants and helpers for the two-fighter combat controller.
package combat_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAttack,
    StShield,
    StCooldown,
    StKo
  } fighter_state_t;

  typedef logic [3:0] hp_t;

  // Ticks a fighter stays immune after taking a hit (COMBAT_INVULN_EN builds only).
  localparam int unsigned InvulnTicks = 10;
  localparam int unsigned InvulnW     = $clog2(InvulnTicks + 1);
  typedef logic [InvulnW-1:0] inv_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic hp_t hp_dec(input hp_t hp);
    return (hp == '0) ? hp : hp - 1'b1;
  endfunction

endpackage

// File: rtl/fighter_fsm.sv
// One fighter's IDLE/ATTACK/SHIELD/COOLDOWN/KO state machine and frame timer.
module fighter_fsm
  import combat_pkg::*;
#(
  parameter int unsigned ATTACK_FRAMES     = 8,
  parameter int unsigned SHIELD_MAX_FRAMES = 30,
  parameter int unsigned COOLDOWN_FRAMES   = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic restart,
  input  logic atk_req,
  input  logic shd_req,
  input  logic hp_zero,
  output logic attack,
  output logic shield,
  output logic ko
);

  localparam int unsigned TimerW =
    $clog2(max3(ATTACK_FRAMES, SHIELD_MAX_FRAMES, COOLDOWN_FRAMES) + 1);
  typedef logic [TimerW-1:0] timer_t;

  localparam timer_t AtkLoad  = timer_t'(ATTACK_FRAMES - 1);
  localparam timer_t ShdLast  = timer_t'(SHIELD_MAX_FRAMES - 1);
  localparam timer_t CoolLoad = timer_t'(COOLDOWN_FRAMES - 1);

  fighter_state_t state_q, state_d;
  timer_t         timer_q, timer_d;
  logic           attack_q, shield_q, ko_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (hp_zero) begin
      state_d = StKo;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (atk_req) begin
            state_d = StAttack;
            timer_d = AtkLoad;
          end else if (shd_req) begin
            state_d = StShield;
            timer_d = '0;
          end
        end
        StAttack: begin
          if (timer_q == '0) begin
            state_d = StCooldown;
            timer_d = CoolLoad;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        StShield: begin
          if (!shd_req || (timer_q == ShdLast)) begin
            state_d = StCooldown;
            timer_d = CoolLoad;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StCooldown: begin
          if (timer_q == '0) begin
            state_d = StIdle;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        StKo: ;
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

  // Restart outranks the tick; outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      attack_q <= 1'b0;
      shield_q <= 1'b0;
      ko_q     <= 1'b0;
    end else if (restart) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      attack_q <= 1'b0;
      shield_q <= 1'b0;
      ko_q     <= 1'b0;
    end else if (tick) begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      attack_q <= (state_d == StAttack);
      shield_q <= (state_d == StShield);
      ko_q     <= (state_d == StKo);
    end
  end

  assign attack = attack_q;
  assign shield = shield_q;
  assign ko     = ko_q;

endmodule

// File: rtl/combat_controller.sv
// Two-fighter combat controller: frame tick, hit resolution and health tracking.
// Define COMBAT_INVULN_EN to add a post-hit immunity window.
module combat_controller
  import combat_pkg::*;
#(
  parameter int unsigned ATTACK_FRAMES     = 8,
  parameter int unsigned SHIELD_MAX_FRAMES = 30,
  parameter int unsigned COOLDOWN_FRAMES   = 15,
  parameter int unsigned MAX_HP            = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       restart,
  input  logic       atk_req,
  input  logic       shd_req,
  input  logic       enemy_atk_req,
  input  logic       enemy_shd_req,
  input  logic       in_range,
  output logic       is_attack,
  output logic       is_shield,
  output logic       is_enemy_attack,
  output logic       is_enemy_shield,
  output logic       game_over,
  output logic       dead,
  output logic [3:0] player_hp,
  output logic [3:0] enemy_hp
);

  localparam hp_t HpInit = hp_t'(MAX_HP);

  logic frame_q, tick;
  logic p_attack, p_shield, p_ko;
  logic e_attack, e_shield, e_ko;
  logic p_open, e_open;
  logic p_hit, e_hit;
  logic p_done_q, e_done_q;
  hp_t  p_hp_q, e_hp_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_clk;
    end
  end

  assign tick = frame_clk & ~frame_q;

  fighter_fsm #(
    .ATTACK_FRAMES    (ATTACK_FRAMES),
    .SHIELD_MAX_FRAMES(SHIELD_MAX_FRAMES),
    .COOLDOWN_FRAMES  (COOLDOWN_FRAMES)
  ) u_player (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .tick   (tick),
    .restart(restart),
    .atk_req(atk_req),
    .shd_req(shd_req),
    .hp_zero(p_hp_q == '0),
    .attack (p_attack),
    .shield (p_shield),
    .ko     (p_ko)
  );

  fighter_fsm #(
    .ATTACK_FRAMES    (ATTACK_FRAMES),
    .SHIELD_MAX_FRAMES(SHIELD_MAX_FRAMES),
    .COOLDOWN_FRAMES  (COOLDOWN_FRAMES)
  ) u_enemy (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .tick   (tick),
    .restart(restart),
    .atk_req(enemy_atk_req),
    .shd_req(enemy_shd_req),
    .hp_zero(e_hp_q == '0),
    .attack (e_attack),
    .shield (e_shield),
    .ko     (e_ko)
  );

  // p_hit: player lands on enemy; e_hit: enemy lands on player. Both may fire together.
  assign p_hit = tick & p_attack & in_range & ~e_shield & ~e_ko & ~p_done_q & e_open;
  assign e_hit = tick & e_attack & in_range & ~p_shield & ~p_ko & ~e_done_q & p_open;

  // hit_done only ever sets while attacking, so clearing it on any non-attack tick
  // guarantees it is clear again by the time the next attack begins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p_hp_q   <= HpInit;
      e_hp_q   <= HpInit;
      p_done_q <= 1'b0;
      e_done_q <= 1'b0;
    end else if (restart) begin
      p_hp_q   <= HpInit;
      e_hp_q   <= HpInit;
      p_done_q <= 1'b0;
      e_done_q <= 1'b0;
    end else if (tick) begin
      if (p_hit) begin
        e_hp_q   <= hp_dec(e_hp_q);
        p_done_q <= 1'b1;
      end else if (!p_attack) begin
        p_done_q <= 1'b0;
      end
      if (e_hit) begin
        p_hp_q   <= hp_dec(p_hp_q);
        e_done_q <= 1'b1;
      end else if (!e_attack) begin
        e_done_q <= 1'b0;
      end
    end
  end

`ifdef COMBAT_INVULN_EN
  inv_t p_inv_q, e_inv_q;

  assign p_open = (p_inv_q == '0);
  assign e_open = (e_inv_q == '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p_inv_q <= '0;
      e_inv_q <= '0;
    end else if (restart) begin
      p_inv_q <= '0;
      e_inv_q <= '0;
    end else if (tick) begin
      if (e_hit) begin
        p_inv_q <= inv_t'(InvulnTicks);
      end else if (!p_open) begin
        p_inv_q <= p_inv_q - 1'b1;
      end
      if (p_hit) begin
        e_inv_q <= inv_t'(InvulnTicks);
      end else if (!e_open) begin
        e_inv_q <= e_inv_q - 1'b1;
      end
    end
  end
`else
  assign p_open = 1'b1;
  assign e_open = 1'b1;
`endif

  assign is_attack       = p_attack;
  assign is_shield       = p_shield;
  assign is_enemy_attack = e_attack;
  assign is_enemy_shield = e_shield;
  assign game_over       = p_ko;
  assign dead            = e_ko;
  assign player_hp       = p_hp_q;
  assign enemy_hp        = e_hp_q;

endmodule

// File: tb/tb_combat_controller.sv
// Scoreboard bench for combat_controller: directed scenarios plus randomized frames.
module tb_combat_controller;

  localparam int unsigned AtkF  = 8;
  localparam int unsigned ShdF  = 30;
  localparam int unsigned CoolF = 15;
  localparam int unsigned MaxHp = 3;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_clk, restart;
  logic       atk_req, shd_req, enemy_atk_req, enemy_shd_req, in_range;
  logic       is_attack, is_shield, is_enemy_attack, is_enemy_shield, game_over, dead;
  logic [3:0] player_hp, enemy_hp;

  combat_controller #(
    .ATTACK_FRAMES    (AtkF),
    .SHIELD_MAX_FRAMES(ShdF),
    .COOLDOWN_FRAMES  (CoolF),
    .MAX_HP           (MaxHp)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .restart        (restart),
    .atk_req        (atk_req),
    .shd_req        (shd_req),
    .enemy_atk_req  (enemy_atk_req),
    .enemy_shd_req  (enemy_shd_req),
    .in_range       (in_range),
    .is_attack      (is_attack),
    .is_shield      (is_shield),
    .is_enemy_attack(is_enemy_attack),
    .is_enemy_shield(is_enemy_shield),
    .game_over      (game_over),
    .dead           (dead),
    .player_hp      (player_hp),
    .enemy_hp       (enemy_hp)
  );

  always #5 Clk = ~Clk;

  // Reference model: index 0 is the player, 1 the enemy; durations counted up in ticks.
  typedef enum int {MIdle, MAttack, MShield, MCool, MKo} mstate_e;
  mstate_e m_st[2];
  int      m_el[2];
  int      m_hp[2];
  bit      m_landed[2];
  bit      m_was_hit[2];
  int      m_hit_at[2];
  int      m_tick;

  logic [13:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] dut_out();
    return {is_attack, is_shield, is_enemy_attack, is_enemy_shield, game_over, dead,
            player_hp, enemy_hp};
  endfunction

  function automatic logic [13:0] model_out();
    return {m_st[0] == MAttack, m_st[0] == MShield, m_st[1] == MAttack, m_st[1] == MShield,
            m_st[0] == MKo, m_st[1] == MKo, 4'(m_hp[0]), 4'(m_hp[1])};
  endfunction

  function automatic void model_reset();
    for (int f = 0; f < 2; f++) begin
      m_st[f]      = MIdle;
      m_el[f]      = 0;
      m_hp[f]      = MaxHp;
      m_landed[f]  = 1'b0;
      m_was_hit[f] = 1'b0;
      m_hit_at[f]  = 0;
    end
  endfunction

  function automatic bit immune(input int d);
`ifdef COMBAT_INVULN_EN
    return m_was_hit[d] && ((m_tick - m_hit_at[d]) <= 10);
`else
    return 1'b0 & m_was_hit[d];
`endif
  endfunction

  function automatic void model_tick(input bit [1:0] atk, input bit [1:0] shd, input bit rng);
    bit hit[2];
    bit zero[2];
    m_tick++;
    for (int f = 0; f < 2; f++) zero[f] = (m_hp[f] == 0);
    for (int f = 0; f < 2; f++) begin
      hit[f] = (m_st[f] == MAttack) && rng && (m_st[1-f] != MShield) && (m_st[1-f] != MKo) &&
               !m_landed[f] && !immune(1 - f);
    end
    for (int f = 0; f < 2; f++) begin
      if (hit[f]) begin
        if (m_hp[1-f] > 0) m_hp[1-f]--;
        m_landed[f]      = 1'b1;
        m_was_hit[1-f]   = 1'b1;
        m_hit_at[1-f]    = m_tick;
      end
    end
    for (int f = 0; f < 2; f++) begin
      if (zero[f]) begin
        m_st[f] = MKo;
      end else begin
        case (m_st[f])
          MIdle: begin
            if (atk[f]) begin
              m_st[f] = MAttack; m_el[f] = 0; m_landed[f] = 1'b0;
            end else if (shd[f]) begin
              m_st[f] = MShield; m_el[f] = 0;
            end
          end
          MAttack: begin
            m_el[f]++;
            if (m_el[f] == AtkF) begin m_st[f] = MCool; m_el[f] = 0; end
          end
          MShield: begin
            m_el[f]++;
            if (!shd[f] || m_el[f] == ShdF) begin m_st[f] = MCool; m_el[f] = 0; end
          end
          MCool: begin
            m_el[f]++;
            if (m_el[f] == CoolF) begin m_st[f] = MIdle; m_el[f] = 0; end
          end
          default: ;
        endcase
      end
    end
    exp_q.push_back(model_out());
  endfunction

  task automatic frame(input bit a, input bit s, input bit ea, input bit es, input bit r);
    @(negedge Clk);
    atk_req = a; shd_req = s; enemy_atk_req = ea; enemy_shd_req = es; in_range = r;
    frame_clk = 1'b1;
    model_tick({ea, a}, {es, s}, r);
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_restart();
    @(negedge Clk);
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    model_reset();
  endtask

  // Monitor: every frame_clk rising edge is a tick; compare one step after the edge.
  initial begin : monitor
    logic        fq;
    logic        seen;
    logic [13:0] e;
    fq = 1'b0;
    forever begin
      @(posedge Clk);
      seen = frame_clk && !fq;
      fq   = frame_clk;
      if (seen) begin
        #1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_empty: got tick with no expectation, required a queued entry");
        end else begin
          e = exp_q.pop_front();
          chk("sb_tick", int'(dut_out()), int'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got no completion, required finish before 5ms");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc;
    bit s_p, s_e;
    Reset_n = 1'b0; frame_clk = 1'b0; restart = 1'b0;
    atk_req = 1'b0; shd_req = 1'b0; enemy_atk_req = 1'b0; enemy_shd_req = 1'b0;
    in_range = 1'b0;
    m_tick = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    chk("in_reset", int'(dut_out()), {6'b0, 4'd3, 4'd3});
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("after_reset", int'(dut_out()), {6'b0, 4'd3, 4'd3});

    // Single attack: 8 active ticks, one hit, 15 cooldown ticks, then idle.
    acc = 0;
    for (int i = 0; i < 8; i++) begin frame(1, 0, 0, 0, 1); acc += int'(is_attack); end
    chk("atk_len", acc, 8);
    chk("atk_hit_once", int'(enemy_hp), 2);
    acc = 0;
    for (int i = 0; i < 15; i++) begin frame(0, 0, 0, 0, 1); acc += int'(is_attack); end
    chk("cool_quiet", acc, 0);
    chk("cool_hp_hold", int'(enemy_hp), 2);
    frame(1, 0, 0, 0, 1);
    chk("cool_ignores_req", int'(is_attack), 0);
    frame(1, 0, 0, 0, 1);
    chk("idle_rearm", int'(is_attack), 1);
    for (int i = 0; i < 23; i++) frame(0, 0, 0, 0, 1);
    chk("second_hit", int'(enemy_hp), 1);
    frame(1, 0, 0, 0, 1);
    frame(0, 0, 0, 0, 1);
    chk("third_hit_hp", int'(enemy_hp), 0);
    chk("dead_not_yet", int'(dead), 0);
    frame(0, 0, 0, 0, 1);
    chk("dead_next_tick", int'(dead), 1);
    acc = 0;
    for (int i = 0; i < 5; i++) begin frame(0, 0, 1, 0, 1); acc += int'(is_enemy_attack); end
    chk("ko_no_attack", acc, 0);
    chk("ko_player_alive", int'(game_over), 0);
    do_restart();
    chk("restart_state", int'(dut_out()), {6'b0, 4'd3, 4'd3});

    // Shield blocks the attack and expires after 30 ticks despite a held request.
    acc = 0;
    frame(1, 0, 0, 1, 1); acc += int'(is_enemy_shield);
    for (int i = 0; i < 39; i++) begin frame(0, 0, 0, 1, 1); acc += int'(is_enemy_shield); end
    chk("shield_len", acc, 30);
    chk("shield_blocks", int'(enemy_hp), 3);
    for (int i = 0; i < 20; i++) frame(0, 0, 0, 0, 1);

    // Trade: both attack on the same tick.
    do_restart();
    frame(1, 0, 1, 0, 1);
    frame(0, 0, 0, 0, 1);
    chk("trade_player", int'(player_hp), 2);
    chk("trade_enemy", int'(enemy_hp), 2);
    for (int i = 0; i < 24; i++) frame(0, 0, 0, 0, 1);

    // Attack wins over shield; asynchronous reset mid-attack.
    do_restart();
    frame(1, 1, 0, 0, 1);
    chk("both_req_attack", int'(is_attack), 1);
    chk("both_req_no_shield", int'(is_shield), 0);
    #2 Reset_n = 1'b0;
    #1 chk("async_reset", int'(dut_out()), {6'b0, 4'd3, 4'd3});
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    frame(0, 0, 0, 0, 1);
    chk("no_pending_hit", int'(enemy_hp), 3);
    chk("attack_aborted", int'(is_attack), 0);

    // Randomized play against the model.
    s_p = 1'b0; s_e = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_restart();
      end else begin
        if ($urandom_range(0, 7) == 0) s_p = ~s_p;
        if ($urandom_range(0, 7) == 0) s_e = ~s_e;
        frame($urandom_range(0, 5) == 0, s_p, $urandom_range(0, 5) == 0, s_e,
              $urandom_range(0, 3) != 0);
      end
    end

    repeat (3) @(negedge Clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
